aes128_key_sched_fwd: RTL

Iterative forward AES-128 key schedule. Accepts a 128-bit cipher key, produces round keys 0..10 one per cycle for the cipher datapath, and holds round key 10 as the `round_key_10` seed for the inverse key expansion used during deciphering. It sits directly upstream of the inverse key expansion and beside the cipher round datapath.

---
 rtl/aes128_key_sched_fwd.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/aes128_key_sched_fwd.sv
// Iterative forward AES-128 key schedule: presents round keys 0..10, one per
// cycle, and holds round key 10 as the seed for the inverse key expansion.
// Optional feature macro: AES128_KEYSCHED_STORE_EN adds an 11-entry round-key
// store with a registered read port (rk_rd_addr / rk_rd_data).
module aes128_key_sched_fwd (
  input  logic         clk_sys,
  input  logic         rst_sys,
  input  logic         key_load,
  input  logic [127:0] cipher_key,
  output logic         key_busy,
  output logic         rkey_valid,
  output logic [127:0] round_key_out,
  output logic [3:0]   round_num_out,
  output logic [127:0] round_key_10,
  output logic         key_done
`ifdef AES128_KEYSCHED_STORE_EN
  ,
  input  logic [3:0]   rk_rd_addr,
  output logic [127:0] rk_rd_data
`endif
);

  typedef enum logic [1:0] {StIdle, StExpand, StDone} state_e;

  state_e       state_q;
  logic [127:0] key_q;
  logic [3:0]   rnd_q;
  logic [7:0]   rcon_q;
  logic         valid_q;
  logic         busy_q;
  logic [127:0] rk10_q;
  logic         done_q;

  logic [127:0] key_next;
  logic [7:0]   rcon_next;
  logic         accept;

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 = product of a^(2^i), i = 1..7; maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] y;
    logic [7:0] p;
    y = a;
    p = 8'h01;
    for (int i = 1; i < 8; i++) begin
      y = gf_mul(y, y);
      p = gf_mul(p, y);
    end
    return p;
  endfunction

  // AES S-box (fwd = 1) or inverse S-box (fwd = 0), computed rather than tabled.
  function automatic logic [7:0] aes128_sbox(input logic [7:0] b, input logic fwd);
    logic [7:0] x;
    logic [7:0] y;
    if (fwd) begin
      x = gf_inv(b);
      y = x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]}
          ^ 8'h63;
    end else begin
      x = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
      y = gf_inv(x);
    end
    return y;
  endfunction

  // Next round key from the registered key and the current Rcon.
  always_comb begin
    logic [31:0] rot;
    logic [31:0] t;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] w3;
    rot = {key_q[23:0], key_q[31:24]};
    t   = {aes128_sbox(rot[31:24], 1'b1), aes128_sbox(rot[23:16], 1'b1),
           aes128_sbox(rot[15:8], 1'b1), aes128_sbox(rot[7:0], 1'b1)} ^ {rcon_q, 24'h0};
    w0  = key_q[127:96] ^ t;
    w1  = key_q[95:64] ^ w0;
    w2  = key_q[63:32] ^ w1;
    w3  = key_q[31:0] ^ w2;
    key_next  = {w0, w1, w2, w3};
    rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
  end

  assign accept = key_load && ((state_q == StIdle) || (state_q == StDone));

  // Control FSM and all registered outputs. round_key_10 and key_done are
  // loaded on the same edge that puts round 10 on the stream.
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      state_q <= StIdle;
      key_q   <= 128'h0;
      rnd_q   <= 4'd0;
      rcon_q  <= 8'h01;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      rk10_q  <= 128'h0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (key_load) begin
            key_q   <= cipher_key;
            rnd_q   <= 4'd0;
            rcon_q  <= 8'h01;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            state_q <= StExpand;
          end
        end
        StExpand: begin
          if (rnd_q == 4'd10) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= StDone;
          end else begin
            key_q  <= key_next;
            rnd_q  <= rnd_q + 4'd1;
            rcon_q <= rcon_next;
            if (rnd_q == 4'd9) begin
              rk10_q <= key_next;
              done_q <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign key_busy      = busy_q;
  assign rkey_valid    = valid_q;
  assign round_key_out = key_q;
  assign round_num_out = rnd_q;
  assign round_key_10  = rk10_q;
  assign key_done      = done_q;

`ifdef AES128_KEYSCHED_STORE_EN
  logic [127:0] rf_q [0:10];
  logic [127:0] rd_q;

  // Store each round key on the edge that presents it; the file is not reset.
  always_ff @(posedge clk_sys) begin
    if (!rst_sys) begin
      if (accept) begin
        rf_q[0] <= cipher_key;
      end else if ((state_q == StExpand) && (rnd_q != 4'd10)) begin
        rf_q[rnd_q + 4'd1] <= key_next;
      end
    end
  end

  // Registered read port; out-of-range addresses read as zero.
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      rd_q <= 128'h0;
    end else if (rk_rd_addr <= 4'd10) begin
      rd_q <= rf_q[rk_rd_addr];
    end else begin
      rd_q <= 128'h0;
    end
  end

  assign rk_rd_data = rd_q;
`endif

endmodule
